// File: rtl/quant_pkg.sv
// Shared types and helpers for the streaming quantizer.
package quant_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_NEAREST = 1'b1
  } round_mode_e;

  localparam int unsigned ShiftW = 3;
  typedef logic [ShiftW-1:0] shift_t;

  localparam int unsigned WideW = 128;
  typedef logic signed [WideW-1:0] wide_t;

  // Saturation limits of a signed value of the given width.
  function automatic wide_t sat_hi(int unsigned width);
    return (wide_t'(1) <<< (width - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_lo(int unsigned width);
    return -(wide_t'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/quant_stream_if.sv
// Row stream, output stream and table write port of the quantizer.
interface quant_stream_if #(
  parameter int unsigned BLOCK_SIZE  = 8,
  parameter int unsigned IN_WIDTH    = 52,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT_WIDTH = 3,
  parameter int unsigned NUM_TABLES  = 2
);
  localparam int unsigned RowW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned SelW = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;

  logic                                 in_valid;
  logic                                 in_ready;
  logic [BLOCK_SIZE-1:0][IN_WIDTH-1:0]  in_row;
  logic [SelW-1:0]                      tbl_sel;
  logic                                 round_mode;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [BLOCK_SIZE-1:0][OUT_WIDTH-1:0] out_row;
  logic [RowW-1:0]                      out_row_idx;
  logic                                 out_last;
  logic                                 tbl_we;
  logic [SelW-1:0]                      tbl_wsel;
  logic [RowW-1:0]                      tbl_wrow;
  logic [RowW-1:0]                      tbl_wcol;
  logic [SHIFT_WIDTH-1:0]               tbl_wdata;

  modport master (
    output in_valid, in_row, tbl_sel, round_mode, out_ready,
    output tbl_we, tbl_wsel, tbl_wrow, tbl_wcol, tbl_wdata,
    input  in_ready, out_valid, out_row, out_row_idx, out_last
  );

  modport slave (
    input  in_valid, in_row, tbl_sel, round_mode, out_ready,
    input  tbl_we, tbl_wsel, tbl_wrow, tbl_wcol, tbl_wdata,
    output in_ready, out_valid, out_row, out_row_idx, out_last
  );
endinterface

// File: rtl/quant_lane.sv
// Combinational shift / round / saturate of one coefficient.
module quant_lane
  import quant_pkg::*;
#(
  parameter int unsigned IN_WIDTH    = 52,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT_WIDTH = 3
) (
  input  logic signed [IN_WIDTH-1:0]  coef,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  input  round_mode_e                 round_mode,
  output logic signed [OUT_WIDTH-1:0] q
);
  // One extra bit so the magnitude of the most negative input is representable.
  localparam int unsigned CW = IN_WIDTH + 1;
  localparam logic signed [CW-1:0] SatHi = CW'(sat_hi(OUT_WIDTH));
  localparam logic signed [CW-1:0] SatLo = CW'(sat_lo(OUT_WIDTH));

  logic signed [CW-1:0] x_ext;
  logic signed [CW-1:0] q_full;
  logic [CW-1:0]        mag;
  logic [CW-1:0]        half;
  logic [CW-1:0]        rnd;

  always_comb begin
    x_ext = {coef[IN_WIDTH-1], coef};
    mag   = x_ext[CW-1] ? -x_ext : x_ext;
    half  = '0;
    if (shift != '0) begin
      half = CW'(1) << (shift - SHIFT_WIDTH'(1));
    end
    rnd = (mag + half) >> shift;
    if (round_mode == RND_NEAREST) begin
      q_full = x_ext[CW-1] ? -$signed(rnd) : $signed(rnd);
    end else begin
      q_full = x_ext >>> shift;
    end

    if (q_full > SatHi) begin
      q = SatHi[OUT_WIDTH-1:0];
    end else if (q_full < SatLo) begin
      q = SatLo[OUT_WIDTH-1:0];
    end else begin
      q = q_full[OUT_WIDTH-1:0];
    end
  end
endmodule

// File: rtl/quant_stream.sv
// Streaming quantizer: one row of coefficients per beat, per-entry shift tables,
// one-cycle registered output with row index and block-last tag.
module quant_stream
  import quant_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE    = 8,
  parameter int unsigned IN_WIDTH      = 52,
  parameter int unsigned OUT_WIDTH     = 16,
  parameter int unsigned SHIFT_WIDTH   = 3,
  parameter int unsigned NUM_TABLES    = 2,
  parameter int unsigned DEFAULT_SHIFT = 0
) (
  input logic           clk,
  input logic           rst,
  quant_stream_if.slave bus
);
  localparam int unsigned RowW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int unsigned SelW = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(BLOCK_SIZE - 1);

  logic [SHIFT_WIDTH-1:0] tbl_q [NUM_TABLES][BLOCK_SIZE][BLOCK_SIZE];

  logic [RowW-1:0]                      row_q, row_d;
  logic [SelW-1:0]                      active_tbl_q, active_tbl_d, cur_tbl;
  logic                                 out_valid_q, out_valid_d;
  logic                                 out_last_q, out_last_d;
  logic [RowW-1:0]                      out_row_idx_q, out_row_idx_d;
  logic [BLOCK_SIZE-1:0][OUT_WIDTH-1:0] out_row_q, out_row_d, lane_q;
  logic                                 in_ready;
  logic                                 accept;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  // Row 0 picks its table straight from the input; later rows reuse the latched one.
  assign cur_tbl  = (row_q == '0) ? bus.tbl_sel : active_tbl_q;

  for (genvar j = 0; j < BLOCK_SIZE; j++) begin : g_lane
    quant_lane #(
      .IN_WIDTH   (IN_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .coef      (bus.in_row[j]),
      .shift     (tbl_q[cur_tbl][row_q][j]),
      .round_mode(round_mode_e'(bus.round_mode)),
      .q         (lane_q[j])
    );
  end

  always_comb begin
    row_d         = row_q;
    active_tbl_d  = active_tbl_q;
    out_valid_d   = out_valid_q && !bus.out_ready;
    out_row_d     = out_row_q;
    out_row_idx_d = out_row_idx_q;
    out_last_d    = out_last_q;
    if (accept) begin
      row_d         = (row_q == LastRow) ? '0 : row_q + RowW'(1);
      active_tbl_d  = cur_tbl;
      out_valid_d   = 1'b1;
      out_row_d     = lane_q;
      out_row_idx_d = row_q;
      out_last_d    = (row_q == LastRow);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q         <= '0;
      active_tbl_q  <= '0;
      out_valid_q   <= 1'b0;
      out_row_q     <= '0;
      out_row_idx_q <= '0;
      out_last_q    <= 1'b0;
    end else begin
      row_q         <= row_d;
      active_tbl_q  <= active_tbl_d;
      out_valid_q   <= out_valid_d;
      out_row_q     <= out_row_d;
      out_row_idx_q <= out_row_idx_d;
      out_last_q    <= out_last_d;
    end
  end

  // Writes land at the edge, so a row accepted in the same cycle sees the old entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TABLES; t++) begin
        for (int r = 0; r < BLOCK_SIZE; r++) begin
          for (int c = 0; c < BLOCK_SIZE; c++) begin
            tbl_q[t][r][c] <= SHIFT_WIDTH'(DEFAULT_SHIFT);
          end
        end
      end
    end else if (bus.tbl_we && (32'(bus.tbl_wsel) < NUM_TABLES)) begin
      tbl_q[bus.tbl_wsel][bus.tbl_wrow][bus.tbl_wcol] <= bus.tbl_wdata;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_row_idx = out_row_idx_q;
  assign bus.out_last    = out_last_q;
endmodule

// File: tb/tb_quant_stream.sv
// Bench for quant_stream: directed vectors, multi-cycle sequences, and a randomized
// run checked against an arithmetic reference model with a scoreboard.
module tb_quant_stream;
  import quant_pkg::*;

  localparam int unsigned BS = 8;
  localparam int unsigned IW = 52;
  localparam int unsigned OW = 8;
  localparam int unsigned NT = 2;
  localparam longint Hi = (longint'(1) <<< (OW - 1)) - 1;
  localparam longint Lo = -(longint'(1) <<< (OW - 1));

  typedef logic [BS-1:0][OW-1:0] orow_t;

  typedef struct {
    shift_t s;
    bit     rnd;
    longint x;
    longint e;
  } vec_t;

  typedef struct {
    orow_t row;
    int    idx;
    bit    last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  quant_stream_if #(
    .BLOCK_SIZE(BS), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(3), .NUM_TABLES(NT)
  ) bus ();

  quant_stream #(
    .BLOCK_SIZE(BS), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(3), .NUM_TABLES(NT),
    .DEFAULT_SHIFT(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int mtbl [NT][BS][BS];
  exp_t sb[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_entry(int t, int r, int c, int d);
    bus.tbl_we    = 1'b1;
    bus.tbl_wsel  = 1'(t);
    bus.tbl_wrow  = 3'(r);
    bus.tbl_wcol  = 3'(c);
    bus.tbl_wdata = 3'(d);
    tick();
    bus.tbl_we = 1'b0;
  endtask

  // Reference: divide by 2^s (floor, or half away from zero), then clamp.
  function automatic longint ref_q(longint x, int s, bit rnd);
    longint d, m, q;
    d = longint'(1) <<< s;
    m = (x < 0) ? -x : x;
    if (rnd) q = (m + d / 2) / d;
    else     q = (x < 0) ? (m + d - 1) / d : m / d;
    if (x < 0) q = -q;
    if (q > Hi) q = Hi;
    if (q < Lo) q = Lo;
    return q;
  endfunction

  function automatic orow_t model_row(longint xs[BS], int t, int r, bit rnd);
    orow_t  e;
    longint q;
    for (int j = 0; j < BS; j++) begin
      q    = ref_q(xs[j], mtbl[t][r][j], rnd);
      e[j] = q[OW-1:0];
    end
    return e;
  endfunction

  function automatic longint rand_x();
    longint v;
    case ($urandom_range(0, 3))
      0: v = longint'($urandom_range(0, 400)) - 200;
      1: v = longint'($urandom_range(0, 1 << 21)) - (longint'(1) <<< 20);
      2: begin
        v = {$urandom, $urandom};
        v = (v <<< 12) >>> 12;
      end
      default: v = $urandom_range(0, 1) ? (longint'(1) <<< 51) - 1 : -(longint'(1) <<< 51);
    endcase
    return v;
  endfunction

  vec_t   vecs[16];
  longint big;
  longint xs[BS];
  orow_t  erow;
  exp_t   e;
  bit     exp_ready;
  int     acc_cnt, act_tbl, r;

  initial begin
    big = longint'(1) <<< 51;
    vecs[0]  = '{3'd2, 1'b0, -5, -2};
    vecs[1]  = '{3'd2, 1'b0, 5, 1};
    vecs[2]  = '{3'd2, 1'b0, -6, -2};
    vecs[3]  = '{3'd2, 1'b1, -5, -1};
    vecs[4]  = '{3'd2, 1'b1, 5, 1};
    vecs[5]  = '{3'd2, 1'b1, -6, -2};
    vecs[6]  = '{3'd3, 1'b1, 13, 2};
    vecs[7]  = '{3'd3, 1'b0, 13, 1};
    vecs[8]  = '{3'd0, 1'b0, 300, 127};
    vecs[9]  = '{3'd0, 1'b0, -300, -128};
    vecs[10] = '{3'd7, 1'b1, -64, -1};
    vecs[11] = '{3'd7, 1'b0, -1, -1};
    vecs[12] = '{3'd0, 1'b1, -big, -128};
    vecs[13] = '{3'd7, 1'b1, big - 1, 127};
    vecs[14] = '{3'd1, 1'b1, -3, -2};
    vecs[15] = '{3'd1, 1'b1, -1, -1};

    bus.in_valid   = 1'b0;
    bus.in_row     = '0;
    bus.tbl_sel    = '0;
    bus.round_mode = 1'b0;
    bus.out_ready  = 1'b1;
    bus.tbl_we     = 1'b0;
    bus.tbl_wsel   = '0;
    bus.tbl_wrow   = '0;
    bus.tbl_wcol   = '0;
    bus.tbl_wdata  = '0;

    // Reset state
    #2;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_row", bus.out_row, 0);
    chk("rst_out_idx", bus.out_row_idx, 0);
    chk("rst_out_last", bus.out_last, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // Directed arithmetic vectors on entry (0,0) of table 0
    foreach (vecs[i]) begin
      do_reset();
      write_entry(0, 0, 0, int'(vecs[i].s));
      bus.in_row     = '0;
      bus.in_row[0]  = vecs[i].x[IW-1:0];
      bus.round_mode = vecs[i].rnd;
      bus.in_valid   = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d_q", i), bus.out_row[0], vecs[i].e[OW-1:0]);
    end
    bus.round_mode = 1'b0;

    // 16 back-to-back rows: index sequence, last flag, no bubbles
    do_reset();
    bus.in_row   = '0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_idx", bus.out_row_idx, 64'(i % BS));
      chk("stream_last", bus.out_last, 64'((i % BS) == BS - 1));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream_drain", bus.out_valid, 0);

    // tbl_sel sampled only on row 0
    do_reset();
    for (int rr = 0; rr < BS; rr++)
      for (int c = 0; c < BS; c++) write_entry(1, rr, c, 4);
    for (int j = 0; j < BS; j++) bus.in_row[j] = 52'd64;
    for (int j = 0; j < BS; j++) erow[j] = 8'd4;
    bus.in_valid = 1'b1;
    for (int i = 0; i < BS; i++) begin
      bus.tbl_sel = 1'(i == 0);
      tick();
      chk($sformatf("tblsel_row%0d", i), bus.out_row, erow);
    end
    bus.in_valid = 1'b0;
    bus.tbl_sel  = '0;

    // Output stall for 5 cycles with a pending input row
    do_reset();
    for (int j = 0; j < BS; j++) begin
      bus.in_row[j] = 52'(longint'(j * 10 - 40));
      erow[j]       = 8'(j * 10 - 40);
    end
    bus.in_valid = 1'b1;
    tick();
    for (int j = 0; j < BS; j++) bus.in_row[j] = 52'(longint'(50 - j * 7));
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ready", bus.in_ready, 0);
      tick();
      chk("stall_row", bus.out_row, erow);
      chk("stall_idx", bus.out_row_idx, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    for (int j = 0; j < BS; j++) erow[j] = 8'(50 - j * 7);
    chk("stall_next_row", bus.out_row, erow);
    chk("stall_next_idx", bus.out_row_idx, 1);
    bus.in_valid = 1'b0;
    tick();
    chk("stall_drain", bus.out_valid, 0);

    // Reset mid-block clears outputs, row counter and tables
    do_reset();
    for (int t = 0; t < NT; t++)
      for (int rr = 0; rr < BS; rr++)
        for (int c = 0; c < BS; c++) write_entry(t, rr, c, (rr + c + t) % 7 + 1);
    bus.in_row   = '0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_row", bus.out_row, 0);
    chk("midrst_idx", bus.out_row_idx, 0);
    chk("midrst_last", bus.out_last, 0);
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    for (int t = 0; t < NT; t++) begin
      for (int rr = 0; rr < BS; rr++) begin
        bus.tbl_sel = 1'(t);
        for (int j = 0; j < BS; j++) begin
          bus.in_row[j] = 52'(longint'(rr * 8 + j - 64));
          erow[j]       = 8'(rr * 8 + j - 64);
        end
        tick();
        chk($sformatf("readback_t%0d_idx", t), bus.out_row_idx, 64'(rr));
        chk($sformatf("readback_t%0d_r%0d", t, rr), bus.out_row, erow);
      end
    end
    bus.in_valid = 1'b0;
    tick();

    // Randomized run against the reference model
    do_reset();
    foreach (mtbl[t, rr, c]) mtbl[t][rr][c] = 0;
    sb.delete();
    acc_cnt = 0;
    act_tbl = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_valid", bus.out_valid, 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("rnd_row", bus.out_row, sb[0].row);
        chk("rnd_idx", bus.out_row_idx, 64'(sb[0].idx));
        chk("rnd_last", bus.out_last, 64'(sb[0].last));
      end
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.round_mode = 1'($urandom_range(0, 1));
      bus.tbl_sel    = 1'($urandom_range(0, 1));
      for (int j = 0; j < BS; j++) begin
        xs[j]         = rand_x();
        bus.in_row[j] = xs[j][IW-1:0];
      end
      bus.tbl_we    = ($urandom_range(0, 7) == 0);
      bus.tbl_wsel  = 1'($urandom_range(0, 1));
      bus.tbl_wrow  = 3'($urandom_range(0, 7));
      bus.tbl_wcol  = 3'($urandom_range(0, 7));
      bus.tbl_wdata = 3'($urandom_range(0, 7));
      #1;
      exp_ready = (sb.size() == 0) || bus.out_ready;
      chk("rnd_ready", bus.in_ready, 64'(exp_ready));
      if (sb.size() != 0 && bus.out_ready) void'(sb.pop_front());
      if (bus.in_valid && exp_ready) begin
        r = acc_cnt % BS;
        if (r == 0) act_tbl = int'(bus.tbl_sel);
        e.row  = model_row(xs, act_tbl, r, bus.round_mode);
        e.idx  = r;
        e.last = (r == BS - 1);
        sb.push_back(e);
        acc_cnt++;
      end
      if (bus.tbl_we) mtbl[bus.tbl_wsel][bus.tbl_wrow][bus.tbl_wcol] = int'(bus.tbl_wdata);
      tick();
    end
    bus.tbl_we   = 1'b0;
    bus.in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/quant_stream.md
# quant_stream

Streaming, table-driven quantizer between the 2-D DCT and the entropy coder. It accepts one row of BLOCK_SIZE signed DCT coefficients per beat over a valid/ready handshake and tracks the row position within each block. Every coefficient is divided by a power of two taken from one of NUM_TABLES runtime-loadable shift tables, with selectable truncate or round-to-nearest behaviour, and the result saturates to OUT_WIDTH. Each output row is tagged with its row index and a block-last flag.

## Interface
- BLOCK_SIZE, 8: coefficients per row and rows per block.
- IN_WIDTH, 52: signed input coefficient width.
- OUT_WIDTH, 16: signed output coefficient width.
- SHIFT_WIDTH, 3: width of one table entry.
- NUM_TABLES, 2: number of shift tables.
- DEFAULT_SHIFT, 0: value every table entry takes on reset.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an input row is presented.
- in_ready  out  1  the block can accept a row.
- in_row  in  BLOCK_SIZE×IN_WIDTH  coefficients, element j = column j.
- tbl_sel  in  $clog2(NUM_TABLES)  table for the block; sampled only on a block's first row.
- round_mode  in  1  0 = truncate (arithmetic shift), 1 = round half away from zero; sampled on every row.
- out_valid  out  1  an output row is held.
- out_ready  in  1  the downstream stage accepts the row.
- out_row  out  BLOCK_SIZE×OUT_WIDTH  quantized coefficients.
- out_row_idx  out  $clog2(BLOCK_SIZE)  row index within the block.
- out_last  out  1  the row is row BLOCK_SIZE-1.
- tbl_we  in  1  table write strobe.
- tbl_wsel, tbl_wrow, tbl_wcol  in  table / row / column index of the entry to write.
- tbl_wdata  in  SHIFT_WIDTH  shift value to write.

## Operation
- Handshake:
  - An input row is accepted when in_valid && in_ready.
  - in_ready = !out_valid || out_ready.
  - An output row is transferred when out_valid && out_ready.
- Row counter:
  - Advances on each accepted row and wraps from BLOCK_SIZE-1 to 0.
  - When the counter is 0, tbl_sel is latched into active_tbl; active_tbl holds until the next block starts.
- Shift selection: coefficient (r, j) uses s = table[active_tbl][r][j], where r is the current counter value. On row 0 the freshly sampled tbl_sel is used directly.
- Arithmetic, per coefficient x:
  - Truncate: q = x >>> s.
  - Round, s>0: q = sign(x)·((|x| + 2^(s-1)) >> s).
  - Round, s=0: q = x.
  - Compute at IN_WIDTH+1 bits so that |most-negative| does not overflow.
- Saturation: clamp q to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Table writes:
  - Accepted on any cycle, including mid-block.
  - A write in cycle N affects rows accepted in cycle N+1 or later.
  - A write and an accepted row that address the same entry in the same cycle: the row uses the old value.
- Stall: while out_valid && !out_ready, out_row, out_row_idx and out_last stay stable and in_ready = 0.

## Timing
- Latency: 1 cycle. A row accepted at edge N appears with out_valid = 1 after edge N.
- Throughput: one row per cycle when out_ready is held high.
- Reset values:
  - out_valid = 0, out_row = 0, out_row_idx = 0, out_last = 0.
  - Row counter = 0, active_tbl = 0.
  - Every table entry = DEFAULT_SHIFT.
  - in_ready = 1 once rst is released.
- Reset mid-block: the partial block is discarded and the next accepted row is row 0.
- in_valid deasserted mid-block: the counter holds; there is no timeout.

## Structure
- Shared package quant_pkg holds:
  - round_mode_e {RND_TRUNC, RND_NEAREST}.
  - shift_t typedef.
  - Saturation-limit helper function.
- Sub-module quant_lane is purely combinational: shift, round and saturate for one coefficient. It is instantiated BLOCK_SIZE times.
- Tables are flop arrays (NUM_TABLES×BLOCK_SIZE×BLOCK_SIZE×SHIFT_WIDTH) with asynchronous reset.

## Test plan
- Table 0 entry (0,0) = 2, truncate, x = -5, 5, -6 → -2, 1, -2. Same inputs with round → -1, 1, -2.
- Entry (0,0) = 3, round, x = 13 → 2; truncate → 1. s = 0 with x = 300, OUT_WIDTH = 8 → 127; x = -300 → -128.
- Stream 16 back-to-back rows with out_ready = 1:
  - out_row_idx runs 0..7 twice.
  - out_last is high on the 8th and 16th rows only.
  - No bubbles.
- tbl_sel = 1 on row 0 and tbl_sel = 0 on rows 1..7 → all 8 rows use table 1. Table 1 all 4, x = 64 → 4 in every row.
- Hold out_ready = 0 for 5 cycles with in_valid = 1 → in_ready = 0, output stable, no row lost or duplicated.
- Assert rst after row 3 of a block → outputs clear immediately. The next accepted row reports out_row_idx = 0, and every table entry reads back as DEFAULT_SHIFT.
